// File: rtl/axi_w_fifo_drain_pkg.sv
// axi_w_fifo_drain_pkg: W-channel packing offsets and skid buffer occupancy states
package axi_w_fifo_drain_pkg;
  localparam int WLAST_BIT = 0;
  localparam int WSTRB_LSB = 1;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL2 = 2'd2} buf_state_e;
  function automatic int pkt_width(input int data_w);
    return data_w + data_w / 8 + 1;
  endfunction
endpackage

// File: rtl/axi_skid_buf2.sv
// axi_skid_buf2: 2-entry valid/ready skid buffer with registered head output
module axi_skid_buf2
  import axi_w_fifo_drain_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  buf_state_e state_q, state_d;
  logic [W-1:0] head_q, head_d, skid_q, skid_d;
  logic push, hs;
  assign in_ready_o = !rst && state_q != FULL2;
  assign push = in_valid_i && in_ready_o;
  assign out_valid_o = state_q != EMPTY;
  assign hs = out_valid_o && out_ready_i;
  assign out_data_o = head_q;
  // head only loads when empty or being consumed; skid catches a push that meets a stall
  always_comb begin
    state_d = buf_state_e'(state_q + 2'(push) - 2'(hs));
    head_d = (push && (state_q == EMPTY || hs)) ? in_data_i : (state_q == FULL2 && hs) ? skid_q : head_q;
    skid_d = (push && !hs && state_q == ONE) ? in_data_i : skid_q;
  end
  // occupancy and slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end
endmodule

// File: rtl/axi_w_fifo_drain.sv
// axi_w_fifo_drain: drains packed W beats from the async FIFO onto the AXI4 W channel
module axi_w_fifo_drain
  import axi_w_fifo_drain_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int PKT_W  = DATA_W + STRB_W + 1,
  parameter int CNT_W  = 8
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic [PKT_W-1:0]  fifo_rdata,
  input  logic              fifo_rempty,
  output logic              fifo_rpop,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              burst_done
);
  logic in_ready, hs, done_q, done_d;
  logic [PKT_W-1:0] head;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign fifo_rpop = in_ready && !fifo_rempty;
  axi_skid_buf2 #(.W(PKT_W)) u_skid (
    .clk(rclk),
    .rst(rrst),
    .in_valid_i(!fifo_rempty),
    .in_ready_o(in_ready),
    .in_data_i(fifo_rdata),
    .out_valid_o(WVALID),
    .out_ready_i(WREADY),
    .out_data_o(head)
  );
  assign WDATA = head[PKT_W-1:WSTRB_LSB+STRB_W];
  assign WSTRB = head[WSTRB_LSB+:STRB_W];
  assign WLAST = head[WLAST_BIT];
  assign hs = WVALID && WREADY;
  assign beat_cnt = cnt_q;
  assign burst_done = done_q;
  // count accepted beats; the last beat clears the count and raises a one-cycle done pulse
  always_comb begin
    cnt_d = !hs ? cnt_q : WLAST ? '0 : cnt_q + CNT_W'(1);
    done_d = hs && WLAST;
  end
  // burst bookkeeping registers
  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_axi_w_fifo_drain.sv
// tb_axi_w_fifo_drain: scoreboard bench with a FIFO model driving the drain block
module tb_axi_w_fifo_drain;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int PKT_W = 37;
  localparam int CNT_W = 8;
  logic rclk = 1'b0;
  logic rrst = 1'b1;
  logic [PKT_W-1:0] fifo_rdata = '0;
  logic fifo_rempty = 1'b1;
  logic fifo_rpop;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic WLAST, WVALID;
  logic WREADY = 1'b0;
  logic [CNT_W-1:0] beat_cnt;
  logic burst_done;
  always #5 rclk = ~rclk;
  axi_w_fifo_drain #(.DATA_W(DATA_W), .STRB_W(STRB_W), .PKT_W(PKT_W), .CNT_W(CNT_W)) dut (
    .rclk(rclk),
    .rrst(rrst),
    .fifo_rdata(fifo_rdata),
    .fifo_rempty(fifo_rempty),
    .fifo_rpop(fifo_rpop),
    .WDATA(WDATA),
    .WSTRB(WSTRB),
    .WLAST(WLAST),
    .WVALID(WVALID),
    .WREADY(WREADY),
    .beat_cnt(beat_cnt),
    .burst_done(burst_done)
  );
  logic [PKT_W-1:0] fq[$];
  logic [PKT_W-1:0] sb[$];
  int hs_cyc[$];
  int checks = 0, failures = 0;
  int mocc = 0, cyc = 0, dut_pops = 0, dones = 0, max_cnt = 0, first_pop = -1;
  logic [CNT_W-1:0] mcnt = '0;
  logic mdone = 1'b0, hold_empty = 1'b0, stalled = 1'b0;
  logic [PKT_W-1:0] stall_pkt = '0;

  task automatic push_word(input logic [31:0] d, input logic [3:0] s, input logic l);
    fq.push_back({d, s, l});
    sb.push_back({d, s, l});
  endtask

  task automatic step();
    logic exp_pop, hs;
    logic [PKT_W-1:0] e;
    fifo_rempty = hold_empty || fq.size() == 0;
    fifo_rdata = fq.size() != 0 ? fq[0] : '0;
    #1;
    exp_pop = !rrst && !fifo_rempty && mocc != 2;
    checks++;
    if (WVALID !== (mocc != 0)) begin failures++; $display("FAIL wvalid cyc=%0d got=%b exp=%b", cyc, WVALID, mocc != 0); end
    checks++;
    if (fifo_rpop !== exp_pop) begin failures++; $display("FAIL rpop cyc=%0d got=%b exp=%b", cyc, fifo_rpop, exp_pop); end
    checks++;
    if (beat_cnt !== mcnt) begin failures++; $display("FAIL beat_cnt cyc=%0d got=%0d exp=%0d", cyc, beat_cnt, mcnt); end
    checks++;
    if (burst_done !== mdone) begin failures++; $display("FAIL burst_done cyc=%0d got=%b exp=%b", cyc, burst_done, mdone); end
    if (stalled) begin
      checks++;
      if ({WDATA, WSTRB, WLAST} !== stall_pkt) begin failures++; $display("FAIL stable cyc=%0d got=%h exp=%h", cyc, {WDATA, WSTRB, WLAST}, stall_pkt); end
    end
    if (burst_done === 1'b1) dones++;
    if (int'(beat_cnt) > max_cnt) max_cnt = int'(beat_cnt);
    if (fifo_rpop === 1'b1) begin
      dut_pops++;
      if (first_pop < 0) first_pop = cyc;
    end
    if (WVALID === 1'b1 && WREADY && !rrst) hs_cyc.push_back(cyc);
    stalled = 1'b0;
    hs = !rrst && mocc != 0 && WREADY;
    if (rrst) begin
      repeat (mocc) if (sb.size() != 0) void'(sb.pop_front());
      mocc = 0;
      mcnt = '0;
      mdone = 1'b0;
    end else begin
      if (hs) begin
        e = {WDATA, WSTRB, WLAST};
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL beat cyc=%0d got=%h exp=none", cyc, e); end
        else begin
          e = sb.pop_front();
          if ({WDATA, WSTRB, WLAST} !== e) begin failures++; $display("FAIL beat cyc=%0d got=%h exp=%h", cyc, {WDATA, WSTRB, WLAST}, e); end
        end
        mcnt = e[0] ? '0 : mcnt + CNT_W'(1);
        mdone = e[0];
      end else mdone = 1'b0;
      if (mocc != 0 && !WREADY) begin
        stalled = 1'b1;
        stall_pkt = {WDATA, WSTRB, WLAST};
      end
      if (exp_pop) void'(fq.pop_front());
      mocc = mocc + int'(exp_pop) - int'(hs);
    end
    @(negedge rclk);
    cyc++;
  endtask

  task automatic drain(input int bound);
    int b = bound;
    while (sb.size() != 0 && b > 0) begin
      step();
      b--;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL drain_timeout left=%0d exp=0", sb.size()); end
    step();
  endtask

  task automatic test_reset();
    rrst = 1'b1;
    WREADY = 1'b1;
    push_word(32'hA0, 4'hF, 1'b0);
    push_word(32'hB0, 4'h3, 1'b1);
    repeat (3) step();
    checks++;
    if (fifo_rpop !== 1'b0 || WVALID !== 1'b0 || beat_cnt !== '0) begin failures++; $display("FAIL reset_state got=%b%b%0d exp=000", fifo_rpop, WVALID, beat_cnt); end
    rrst = 1'b0;
    first_pop = -1;
    step();
    checks++;
    if (first_pop != cyc - 1) begin failures++; $display("FAIL first_pop got=%0d exp=%0d", first_pop, cyc - 1); end
    drain(20);
  endtask

  task automatic test_streaming();
    hs_cyc.delete();
    dones = 0;
    first_pop = -1;
    WREADY = 1'b1;
    for (int i = 1; i <= 4; i++) push_word(32'h11 * i, 4'hF, i == 4);
    drain(20);
    checks++;
    if (hs_cyc.size() != 4 || hs_cyc[3] - hs_cyc[0] != 3) begin failures++; $display("FAIL stream_beats got=%0d exp=4 consecutive", hs_cyc.size()); end
    checks++;
    if (hs_cyc.size() == 0 || hs_cyc[0] != first_pop + 1) begin failures++; $display("FAIL stream_latency got=%0d exp=%0d", hs_cyc.size() != 0 ? hs_cyc[0] : -1, first_pop + 1); end
    checks++;
    if (dones != 1) begin failures++; $display("FAIL stream_done got=%0d exp=1", dones); end
  endtask

  task automatic test_backpressure();
    WREADY = 1'b0;
    for (int i = 0; i < 6; i++) push_word(32'hC000 + i, 4'h5 + 4'(i), i == 5);
    dut_pops = 0;
    repeat (5) step();
    checks++;
    if (dut_pops != 2) begin failures++; $display("FAIL bp_pops got=%0d exp=2", dut_pops); end
    checks++;
    if (WDATA !== 32'hC000) begin failures++; $display("FAIL bp_head got=%h exp=0000c000", WDATA); end
    WREADY = 1'b1;
    drain(30);
  endtask

  task automatic test_bubbles();
    int k = 0;
    WREADY = 1'b1;
    for (int i = 0; i < 6; i++) push_word(32'hB0B0_0000 + i, 4'(i), i == 5);
    while (sb.size() != 0 && k < 40) begin
      hold_empty = k % 2 == 1;
      step();
      k++;
    end
    hold_empty = 1'b0;
    drain(10);
  endtask

  task automatic test_midreset();
    int k = 0;
    WREADY = 1'b1;
    hs_cyc.delete();
    for (int i = 0; i < 8; i++) push_word(32'hD000 + i, 4'hF, i == 7);
    while (hs_cyc.size() < 2 && k < 20) begin
      step();
      k++;
    end
    WREADY = 1'b0;
    repeat (2) step();
    checks++;
    if (fifo_rpop !== 1'b0 || WVALID !== 1'b1) begin failures++; $display("FAIL full2 got=%b%b exp=01", fifo_rpop, WVALID); end
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    fq.delete();
    sb.delete();
    checks++;
    if (WVALID !== 1'b0 || beat_cnt !== '0) begin failures++; $display("FAIL midreset got=%b/%0d exp=0/0", WVALID, beat_cnt); end
    WREADY = 1'b1;
    for (int i = 0; i < 3; i++) push_word(32'hE000 + i, 4'h9, i == 2);
    drain(20);
  endtask

  task automatic test_wrap();
    dones = 0;
    max_cnt = 0;
    WREADY = 1'b1;
    for (int i = 0; i < 256; i++) push_word(32'(i), 4'(i), i == 255);
    drain(400);
    checks++;
    if (max_cnt != 255) begin failures++; $display("FAIL wrap_max got=%0d exp=255", max_cnt); end
    checks++;
    if (dones != 1) begin failures++; $display("FAIL wrap_done got=%0d exp=1", dones); end
  endtask

  initial begin
    @(negedge rclk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubbles();
    test_midreset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_w_fifo_drain.md
Name: axi_w_fifo_drain

Overview:
- Read-domain consumer of the master write-data async FIFO.
- Pops packed {WDATA, WSTRB, WLAST} beats from the FIFO read port and drives the AXI4 W channel with registered outputs.
- Uses a 2-entry skid buffer to sustain 1 beat/cycle under WREADY backpressure.
- Tracks beats per burst and pulses a burst-complete strobe for the bridge's B-channel bookkeeping.

Parameters:
- DATA_W, 32, WDATA width.
- STRB_W, DATA_W/8, WSTRB width.
- PKT_W, DATA_W+STRB_W+1, packed FIFO word width; must equal `M_W_DATASIZE.
- CNT_W, 8, beat counter width (AXI4 max burst of 256 beats).

Ports:
- rclk  in  1  read-side clock (same domain as FIFO read port).
- rrst  in  1  synchronous active-high reset.
- fifo_rdata  in  PKT_W  FIFO head word, valid combinationally whenever fifo_rempty=0; packing {WDATA[PKT_W-1:STRB_W+1], WSTRB[STRB_W:1], WLAST[0]}.
- fifo_rempty  in  1  FIFO empty flag.
- fifo_rpop  out  1  pop strobe to FIFO; combinational.
- WDATA  out  DATA_W  AXI write data.
- WSTRB  out  STRB_W  AXI byte strobes.
- WLAST  out  1  last beat of burst.
- WVALID  out  1  AXI valid.
- WREADY  in  1  AXI ready from slave/interconnect.
- beat_cnt  out  CNT_W  beats accepted so far in the current burst.
- burst_done  out  1  one-cycle pulse, registered, in the cycle after the handshake of a beat with WLAST=1.

Behaviour:
- Clock and reset: one clock, rclk. Reset rrst is synchronous and active-high.
- Reset state: entry count 0, both buffer slots 0, WVALID=0, WDATA/WSTRB/WLAST=0, beat_cnt=0, burst_done=0.
- fifo_rpop is 0 while rrst=1.
- Buffer states:
  - EMPTY: 0 entries.
  - ONE: head valid.
  - FULL2: head plus skid valid.
- Signal definitions:
  - WVALID = (state != EMPTY).
  - W* outputs always show the head slot.
  - fifo_rpop = !fifo_rempty && (state != FULL2).
  - hs = WVALID && WREADY.
- Transitions:
  - EMPTY:
    - pop -> ONE; popped word loads head.
  - ONE:
    - pop && !hs -> FULL2; word loads skid.
    - pop && hs -> ONE; word loads head directly.
    - !pop && hs -> EMPTY.
    - else hold.
  - FULL2 (no pop possible):
    - hs -> ONE; skid moves to head.
    - else hold.
- Latency: word present with fifo_rempty=0 at edge N is on W outputs with WVALID=1 after edge N+1.
- Throughput: 1 beat/cycle with WREADY held high.
- AXI rule: once WVALID=1, WDATA/WSTRB/WLAST must not change and WVALID must not drop until hs. The head slot is written only when it is empty or being consumed in the same cycle.
- Beat counter:
  - On hs with WLAST=0: beat_cnt += 1, wrapping modulo 2^CNT_W with no error.
  - On hs with WLAST=1: beat_cnt <= 0 and burst_done <= 1 for the next cycle.
  - burst_done is 0 otherwise.
- Simultaneous events:
  - FIFO going empty in the same cycle as a pop: the pop is valid; rempty is sampled combinationally.
  - rempty asserting while buffered entries remain: the buffer keeps draining.
- Reset mid-burst: buffered beats are discarded and the counter is cleared. Flushing the FIFO is the reset controller's responsibility.
- No data transformation: fields are passed through bit-exact.

Decomposition:
- Shared package: W-channel packing macros/localparams (WDATA/WSTRB/WLAST bit offsets, PKT_W), and the buffer state enum {EMPTY, ONE, FULL2}.
- Natural sub-module: axi_skid_buf2, a generic 2-entry valid/ready skid buffer.
- Top level: FIFO adapter (rpop/rempty to valid/ready) plus the beat counter and burst_done logic.

Test Plan:
- Reset: assert rrst for 3 cycles with fifo_rempty=0 -> fifo_rpop=0, WVALID=0, beat_cnt=0. After release, first pop occurs on the next edge.
- Streaming: 4-beat burst with data 0x11..0x44, WSTRB=0xF, WLAST on beat 4, WREADY=1 -> beats appear on consecutive cycles starting 1 cycle after the first pop; beat_cnt goes 1,2,3,0; burst_done pulses once.
- Backpressure: WREADY=0 for 5 cycles while the FIFO holds 6 words -> exactly 2 pops then fifo_rpop=0; W outputs are stable on the first word. After WREADY rises, order is preserved with no loss or duplication.
- Bubbles: fifo_rempty toggles every other cycle with WREADY=1 -> WVALID toggles with 1-cycle lag; data order is preserved.
- Mid-burst reset: reset after the 2nd beat of 8 with FULL2 occupied -> WVALID=0 and beat_cnt=0 next cycle. The next burst's first beat shows beat_cnt progression from 1.
- Counter wrap: 256-beat burst with WLAST only on beat 256 -> beat_cnt reaches 255, then 0 on the last hs; burst_done pulses once.
